// File: rtl/s_xfer_ctrl.sv
// Stream transfer controller: moves one bounded run of tokens from an upstream
// valid/ready source to a downstream sink through a single output register.
module s_xfer_ctrl #(
    parameter int SIZECOUNT  = 12,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [SIZECOUNT-1:0]  size,
    input  logic                  abort,
    input  logic [SIZECOUNT-1:0]  count,
    output logic                  clear,
    output logic                  e_cnt,
    output logic                  go,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_valid,
    output logic                  out_last,
    input  logic                  out_ready,
    output logic                  busy,
    output logic                  done,
    output logic                  err,
    output logic                  aborted
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_FLUSH,
        S_DONE
    } state_t;

    state_t               state_reg;
    logic [SIZECOUNT-1:0] size_reg;
    logic                 last_tok;
    logic                 out_take;

    // count is the pre-increment value, so the final token is accepted at size-1
    assign last_tok = (count == size_reg - SIZECOUNT'(1));
    assign out_take = out_valid && out_ready;

    always_comb begin
        clear    = (state_reg == S_IDLE);
        e_cnt    = (state_reg == S_RUN);
        in_ready = (state_reg == S_RUN) && !abort && (!out_valid || out_ready);
        go       = in_valid && in_ready;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg <= S_IDLE;
            size_reg  <= '0;
            out_data  <= '0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
            aborted   <= 1'b0;
        end else begin
            done    <= 1'b0;
            err     <= 1'b0;
            aborted <= 1'b0;
            case (state_reg)
                S_IDLE: begin
                    if (start) begin
                        if (size != '0) begin
                            size_reg  <= size;
                            state_reg <= S_RUN;
                            busy      <= 1'b1;
                        end else begin
                            err <= 1'b1;
                        end
                    end
                end
                S_RUN: begin
                    if (abort) begin
                        state_reg <= S_IDLE;
                        out_valid <= 1'b0;
                        out_last  <= 1'b0;
                        busy      <= 1'b0;
                        aborted   <= 1'b1;
                    end else if (go) begin
                        out_data  <= in_data;
                        out_valid <= 1'b1;
                        out_last  <= last_tok;
                        if (last_tok) begin
                            state_reg <= S_FLUSH;
                        end
                    end else if (out_take) begin
                        out_valid <= 1'b0;
                        out_last  <= 1'b0;
                    end
                end
                S_FLUSH: begin
                    if (abort) begin
                        state_reg <= S_IDLE;
                        out_valid <= 1'b0;
                        out_last  <= 1'b0;
                        busy      <= 1'b0;
                        aborted   <= 1'b1;
                    end else if (out_take) begin
                        out_valid <= 1'b0;
                        out_last  <= 1'b0;
                        state_reg <= S_DONE;
                        done      <= 1'b1;
                    end
                end
                S_DONE: begin
                    state_reg <= S_IDLE;
                    busy      <= 1'b0;
                end
                default: begin
                    state_reg <= S_IDLE;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_s_xfer_ctrl.sv
// Randomized scoreboard bench for s_xfer_ctrl; models the attached token counter.
module tb_s_xfer_ctrl;

    localparam int SC = 12;
    localparam int DW = 32;
    localparam int EV_DONE  = 0;
    localparam int EV_ERR   = 1;
    localparam int EV_ABORT = 2;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          start = 1'b0;
    logic [SC-1:0] size = '0;
    logic          abort = 1'b0;
    logic [SC-1:0] count;
    logic          clear, e_cnt, go;
    logic [DW-1:0] in_data = '0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [DW-1:0] out_data;
    logic          out_valid, out_last;
    logic          out_ready = 1'b0;
    logic          busy, done, err, aborted;

    typedef struct {
        logic [DW-1:0] data;
        logic          last;
    } tok_t;

    typedef struct {
        int kind;
        int cnt;
    } evt_t;

    tok_t exp_tok[$];
    evt_t exp_evt[$];
    int   n_cmp  = 0;
    int   n_fail = 0;

    s_xfer_ctrl #(.SIZECOUNT(SC), .DATA_WIDTH(DW)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .size     (size),
        .abort    (abort),
        .count    (count),
        .clear    (clear),
        .e_cnt    (e_cnt),
        .go       (go),
        .in_data  (in_data),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .out_data (out_data),
        .out_valid(out_valid),
        .out_last (out_last),
        .out_ready(out_ready),
        .busy     (busy),
        .done     (done),
        .err      (err),
        .aborted  (aborted)
    );

    always #5 clk = ~clk;

    // Companion token counter
    always @(posedge clk or negedge rst) begin
        if (!rst)              count <= '0;
        else if (clear)        count <= '0;
        else if (e_cnt && go)  count <= count + 1'b1;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic take_evt(input int kind);
        evt_t e;
        if (exp_evt.size() == 0) begin
            chk("event_unexpected_kind", 64'(kind), 64'hFF);
        end else begin
            e = exp_evt.pop_front();
            chk("event_kind", 64'(kind), 64'(e.kind));
            if (kind == EV_DONE) begin
                chk("done_count", 64'(count), 64'(e.cnt));
                chk("done_busy", 64'(busy), 64'd1);
                chk("tokens_left_at_done", 64'(exp_tok.size()), 64'd0);
            end
            if (kind == EV_ABORT) exp_tok.delete();
        end
    endtask

    // Monitor: compares every output handshake and status pulse with the queues
    always @(negedge clk) begin
        tok_t t;
        if (rst) begin
            if (out_valid && out_ready) begin
                if (exp_tok.size() == 0) begin
                    chk("token_unexpected", {32'h0, out_data}, 64'hFFFF_FFFF_FFFF_FFFF);
                end else begin
                    t = exp_tok.pop_front();
                    chk("out_data", 64'(out_data), 64'(t.data));
                    chk("out_last", 64'(out_last), 64'(t.last));
                end
            end
            if (done)    take_evt(EV_DONE);
            if (err)     take_evt(EV_ERR);
            if (aborted) take_evt(EV_ABORT);
            if (out_valid && !out_ready) chk("in_ready_backpressure", 64'(in_ready), 64'd0);
            if (!busy) chk("in_ready_idle", 64'(in_ready), 64'd0);
        end
    end

    // rpct < 0 selects the fixed out_ready pattern 1,0,0,1,0,0,...
    task automatic run_xfer(input int sz, input int abort_after, input int vpct,
                            input int rpct, input bit poke, input bit directed);
        logic [DW-1:0] d[$];
        tok_t t;
        evt_t e;
        int   idx = 0;
        int   cyc = 0;
        int   busy_cyc = 0;
        bit   acc, ab_now, ab_done;
        ab_done = 1'b0;
        for (int i = 0; i < sz; i++) begin
            d.push_back(directed ? DW'(32'h10 + i) : DW'($urandom));
            t.data = d[i];
            t.last = (i == sz - 1);
            exp_tok.push_back(t);
        end
        e.kind = (abort_after >= 0) ? EV_ABORT : EV_DONE;
        e.cnt  = sz;
        exp_evt.push_back(e);
        $display("xfer size=%0d abort_after=%0d valid_pct=%0d ready_pct=%0d poke=%0b",
                 sz, abort_after, vpct, rpct, poke);
        start = 1'b1;
        size  = SC'(sz);
        step();
        start = 1'b0;
        while (1) begin
            in_valid  = (idx < sz) && ($urandom_range(99) < vpct);
            in_data   = (idx < sz) ? d[idx] : DW'($urandom);
            out_ready = (rpct < 0) ? (cyc % 3 == 0) : ($urandom_range(99) < rpct);
            start     = poke && (cyc == 2);
            size      = SC'(sz + 1);
            abort     = 1'b0;
            ab_now    = 1'b0;
            if (abort_after >= 0 && !ab_done && idx == abort_after) begin
                abort     = 1'b1;
                in_valid  = 1'b1;
                out_ready = 1'b0;
                ab_done   = 1'b1;
                ab_now    = 1'b1;
            end
            @(negedge clk);
            if (cyc == 0) begin
                chk("busy_after_start", 64'(busy), 64'd1);
                chk("count_after_start", 64'(count), 64'd0);
            end else if (!busy) begin
                break;
            end
            busy_cyc++;
            if (ab_now) begin
                chk("go_during_abort", 64'(go), 64'd0);
                chk("in_ready_during_abort", 64'(in_ready), 64'd0);
            end
            acc = in_valid && in_ready;
            step();
            if (acc) idx++;
            cyc++;
            if (cyc > 1000) begin
                chk("xfer_timeout", 64'd1, 64'd0);
                break;
            end
        end
        start    = 1'b0;
        abort    = 1'b0;
        in_valid = 1'b0;
        if (abort_after >= 0) begin
            chk("out_valid_after_abort", 64'(out_valid), 64'd0);
            step();
            chk("count_cleared_after_abort", 64'(count), 64'd0);
        end else if (vpct >= 100 && rpct >= 100) begin
            chk("full_rate_busy_cycles", 64'(busy_cyc), 64'(sz + 2));
        end
        out_ready = 1'b0;
        step();
    endtask

    task automatic run_zero();
        evt_t e;
        e.kind = EV_ERR;
        e.cnt  = 0;
        exp_evt.push_back(e);
        $display("zero-size start");
        start    = 1'b1;
        size     = '0;
        in_valid = 1'b1;
        step();
        start = 1'b0;
        repeat (3) begin
            @(negedge clk);
            chk("zero_busy", 64'(busy), 64'd0);
            chk("zero_in_ready", 64'(in_ready), 64'd0);
        end
        step();
        in_valid = 1'b0;
    endtask

    task automatic run_reset_mid();
        logic [DW-1:0] d[$];
        tok_t t;
        evt_t e;
        int   idx = 0;
        int   cyc = 0;
        bit   acc;
        for (int i = 0; i < 5; i++) begin
            d.push_back(DW'($urandom));
            t.data = d[i];
            t.last = (i == 4);
            exp_tok.push_back(t);
        end
        e.kind = EV_DONE;
        e.cnt  = 5;
        exp_evt.push_back(e);
        $display("reset mid-transfer, size=5");
        start = 1'b1;
        size  = SC'(5);
        step();
        start     = 1'b0;
        out_ready = 1'b1;
        while (idx < 2 && cyc < 50) begin
            in_data  = d[idx];
            in_valid = 1'b1;
            @(negedge clk);
            acc = in_valid && in_ready;
            step();
            if (acc) idx++;
            cyc++;
        end
        in_valid = 1'b0;
        chk("reset_test_accepts", 64'(idx), 64'd2);
        #3 rst = 1'b0;
        #1;
        exp_tok.delete();
        exp_evt.delete();
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_out_last", 64'(out_last), 64'd0);
        chk("rst_out_data", 64'(out_data), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_pulses", {61'd0, done, err, aborted}, 64'd0);
        chk("rst_comb", {60'd0, clear, e_cnt, go, in_ready}, 64'b1000);
        repeat (2) @(negedge clk);
        #2 rst = 1'b1;
        out_ready = 1'b0;
        step();
    endtask

    initial begin
        #1;
        chk("reset_regs", {57'd0, out_valid, out_last, busy, done, err, aborted, |out_data}, 64'd0);
        chk("reset_comb", {60'd0, clear, e_cnt, go, in_ready}, 64'b1000);
        repeat (3) @(negedge clk);
        #2 rst = 1'b1;
        step();

        run_xfer(4, -1, 100, 100, 1'b0, 1'b1);
        run_xfer(3, -1, 100, -1, 1'b0, 1'b1);
        run_zero();
        run_xfer(8, 3, 100, 100, 1'b0, 1'b0);
        run_reset_mid();
        run_xfer(2, -1, 100, 100, 1'b0, 1'b0);
        run_xfer(6, -1, 80, 70, 1'b1, 1'b0);
        run_xfer(1, -1, 100, 100, 1'b0, 1'b0);

        for (int n = 0; n < 40; n++) begin
            int sz;
            int r;
            sz = $urandom_range(12, 1);
            r  = $urandom_range(9, 0);
            if (r == 0) run_zero();
            else if (r == 1) run_xfer(sz, $urandom_range(sz, 0), $urandom_range(100, 30),
                                      $urandom_range(100, 30), 1'b0, 1'b0);
            else if (r == 2) run_xfer(sz, -1, 100, 100, 1'b0, 1'b0);
            else run_xfer(sz, -1, $urandom_range(100, 30), $urandom_range(100, 30),
                          1'($urandom_range(1, 0)), 1'b0);
        end

        repeat (3) step();
        chk("tokens_outstanding", 64'(exp_tok.size()), 64'd0);
        chk("events_outstanding", 64'(exp_evt.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout, expected bench completion");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/s_xfer_ctrl.md
# s_xfer_ctrl

Stream transfer controller for the coprocessor stream path. It runs a single bounded transfer of `size` tokens from an upstream valid/ready source to a downstream valid/ready sink through a one-deep output register. It drives the companion token counter `s_cnt` (`clear`, `e_cnt`, `go`) and uses that counter's `count` value to detect the last token. It flags the final token, pulses `done` on completion, and supports abort and error reporting.

## Interface

Parameters:
- `SIZECOUNT`, 12: width of `size` and `count`; must match the attached `s_cnt`.
- `DATA_WIDTH`, 32: token data width.

Ports:
- `clk`, in, 1: single clock; all logic is on the rising edge.
- `rst`, in, 1: asynchronous, active-low reset.
- `start`, in, 1: begin a transfer; sampled only in IDLE.
- `size`, in, SIZECOUNT: token count for the transfer; latched on an accepted `start`.
- `abort`, in, 1: cancel the transfer in progress.
- `count`, in, SIZECOUNT: tokens accepted so far, from `s_cnt`.
- `clear`, out, 1: counter clear, to `s_cnt`.
- `e_cnt`, out, 1: counter enable, to `s_cnt`.
- `go`, out, 1: counter increment; high on an accepted input token.
- `in_data`, in, DATA_WIDTH: upstream token.
- `in_valid`, in, 1: upstream token is valid.
- `in_ready`, out, 1: block accepts the upstream token.
- `out_data`, out, DATA_WIDTH: registered token.
- `out_valid`, out, 1: `out_data` is valid.
- `out_last`, out, 1: `out_data` is the final token of the transfer.
- `out_ready`, in, 1: downstream accepts the token.
- `busy`, out, 1: high in any state other than IDLE.
- `done`, out, 1: one-cycle completion pulse.
- `err`, out, 1: one-cycle pulse when `start` arrives with `size`==0.
- `aborted`, out, 1: one-cycle pulse when an abort is taken.

## Operation

States: IDLE, RUN, FLUSH, DONE.

IDLE
- `clear`=1, `e_cnt`=0, `in_ready`=0.
- On `start` with `size`!=0: latch `size` into `size_r`; go to RUN.
- On `start` with `size`==0: pulse `err` next cycle; stay in IDLE. No `done` pulse.

RUN
- `e_cnt`=1 and `clear`=0.
- `in_ready` = !`out_valid` || `out_ready`.
- `go` = `in_valid` && `in_ready`.
- On `go`: load `in_data` into `out_data`, set `out_valid`=1, and set `out_last` = (`count` == `size_r`-1).
- On `go` with `count` == `size_r`-1: go to FLUSH.
- When `out_ready` && `out_valid` with no `go` in the same cycle: `out_valid` drops to 0.

FLUSH
- `in_ready`=0, `e_cnt`=0.
- On `out_valid` && `out_ready`: clear `out_valid` and `out_last`; go to DONE.

DONE
- `done`=1 for exactly one cycle; then IDLE.

Abort
- `abort` in RUN or FLUSH: next cycle state=IDLE, `out_valid`=0, `out_last`=0, `aborted`=1 for one cycle, no `done` pulse.
- `abort` outranks `go` and `out_ready` in the same cycle. `in_ready`=0 and `go`=0 while `abort` is high.
- `abort` in IDLE or DONE is ignored. In DONE the `done` pulse still occurs.

Other rules
- `start` is ignored while `busy`.
- `clear`, `e_cnt`, `go` and `in_ready` are combinational from state and inputs. All other outputs are registered.
- `count` never exceeds `size_r`, so no wrap-around occurs. `size` is limited to 1..2^SIZECOUNT-1.
- `out_data` holds its value when `out_valid`=0.

## Timing

- Reset (`rst`=0, asynchronous) forces: state=IDLE, `out_data`=0, `out_valid`=0, `out_last`=0, `busy`=0, `done`=0, `err`=0, `aborted`=0.
- Reset outputs: `clear`=1, `e_cnt`=0, `go`=0, `in_ready`=0.
- A reset taken mid-transfer discards the transfer with no `done` or `aborted` pulse.
- `start` in cycle N: `busy`=1 from N+1. `count`=0 at N+1, because `clear` was high at the N edge.
- Input-to-output latency is 1 cycle. Sustained throughput is 1 token per cycle when `out_ready`=1.
- `count` lags `go` by one cycle. The last-token compare uses the pre-increment `count`.
- Final handshake in cycle M: DONE in M+1 with `done`=1 and `busy`=1; IDLE in M+2 with `busy`=0.
- Minimum transfer of `size`=1 with ready upstream and downstream: `start` at N, accept at N+1, output handshake at N+2, `done` at N+3.

## Test plan

- **Basic transfer:** `size`=4, `in_valid`=1 and `out_ready`=1 continuously, data 0x10..0x13 → 4 outputs in consecutive cycles, `out_last` only on 0x13, `done` one cycle after the 0x13 handshake, `count`=4 at end.
- **Backpressure:** `size`=3, `out_ready` toggling 1,0,0,1,... → no token lost or duplicated, `in_ready`=0 whenever `out_valid` && !`out_ready`, output order 0..2 preserved, a single `done` pulse.
- **Zero size:** `start` with `size`=0 → `err`=1 for one cycle, `busy` stays 0, no `done`, `in_ready` stays 0.
- **Abort:** `size`=8, `abort` after 3 tokens while a 4th is offered → `aborted` pulse, `out_valid`=0 next cycle, 4th token not accepted (`go`=0), `clear` high next cycle so `count` reads 0, no `done`.
- **Reset mid-transfer:** `rst`=0 during RUN with `size`=5 after 2 tokens → all registered outputs 0 immediately. After release, a new `start` with `size`=2 completes normally.
- **Start ignored while busy:** `start` pulsed during RUN with a different `size` → the original `size` transfer completes unchanged.
